// File: rtl/main_controller.sv
// Washing machine top-level sequencer.
//
// Runs the wash cycle FSM (fill, heat, wash, drain, rinse, spin), holds the selected
// temperature and spin code, times each phase and watches three fault monitors
// (water flow, drainage, vibration). One clock cycle is 200 ms.
//
// Ports:
//   clk, reset                  clock, asynchronous active-low reset
//   start, stop, pause,
//   continue_signal             user buttons, level-sampled
//   door_locked, clothes_loaded door latch / load present
//   load_weight[7:0]            load weight, accepted when 0 < w <= MAX_LOAD
//   vibration_sensor            1 = excessive vibration
//   temperature_adc_sensor[6:0] water temperature in degC
//   wash_mode[2:0]              programme select, latched by confirm_wash_mode
//   change_temperature,
//   change_spin_speed           manual selection steps on rising edge (START only)
//   water_level_sensor[9:0]     water level
//   cycle_complete_led, door_lock, water_valve, heater, drain_pump
//   drum_motor[3:0]             drum speed level, 0 = off
//   water_flow_error_led, drainage_error_led, vibration_error_led  latched faults
module main_controller #(
  parameter int unsigned MAX_LOAD      = 200,
  parameter int unsigned WASH_CYCLES   = 30,
  parameter int unsigned RINSE_CYCLES  = 20,
  parameter int unsigned SPIN_CYCLES   = 20,
  parameter int unsigned FILL_TIMEOUT  = 50,
  parameter int unsigned DRAIN_TIMEOUT = 50,
  parameter int unsigned VIB_LIMIT     = 10,
  parameter int unsigned EMPTY_LEVEL   = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       stop,
  input  logic       pause,
  input  logic       continue_signal,
  input  logic       door_locked,
  input  logic       clothes_loaded,
  input  logic [7:0] load_weight,
  input  logic       vibration_sensor,
  input  logic [6:0] temperature_adc_sensor,
  input  logic [2:0] wash_mode,
  input  logic       confirm_wash_mode,
  input  logic       change_temperature,
  input  logic       change_spin_speed,
  input  logic [9:0] water_level_sensor,
  output logic       cycle_complete_led,
  output logic       door_lock,
  output logic       water_valve,
  output logic       heater,
  output logic       drain_pump,
  output logic [3:0] drum_motor,
  output logic       water_flow_error_led,
  output logic       drainage_error_led,
  output logic       vibration_error_led
);

  typedef enum logic [3:0] {
    StIdle        = 4'd0,
    StStart       = 4'd1,
    StFillInitial = 4'd2,
    StHeat        = 4'd3,
    StWash        = 4'd4,
    StDrainWash   = 4'd5,
    StFillRinse   = 4'd6,
    StRinse       = 4'd7,
    StDrainRinse  = 4'd8,
    StSpin        = 4'd9,
    StComplete    = 4'd10,
    StPaused      = 4'd11,
    StStopDrain   = 4'd12,
    StError       = 4'd13
  } state_e;

  localparam logic [7:0] MaxLoad      = 8'(MAX_LOAD);
  localparam logic [7:0] WashLast     = 8'(WASH_CYCLES - 1);
  localparam logic [7:0] RinseLast    = 8'(RINSE_CYCLES - 1);
  localparam logic [7:0] SpinLast     = 8'(SPIN_CYCLES - 1);
  localparam logic [7:0] FillTimeout  = 8'(FILL_TIMEOUT);
  localparam logic [7:0] DrainTimeout = 8'(DRAIN_TIMEOUT);
  localparam logic [7:0] VibLimit     = 8'(VIB_LIMIT);
  localparam logic [9:0] EmptyLevel   = 10'(EMPTY_LEVEL);

  state_e     r_state, r_prev_state;
  logic [7:0] r_timer, r_fill_cnt, r_drain_cnt, r_vib_cnt;
  logic [6:0] r_sel_temp;
  logic [1:0] r_spin_code;
  logic       r_chg_temp_q, r_chg_spin_q;

  state_e     w_state_next, w_prev_next;
  logic [7:0] w_timer_next, w_fill_cnt_next, w_drain_cnt_next, w_vib_cnt_next;
  logic [6:0] w_sel_temp_next;
  logic [1:0] w_spin_code_next;

  logic [10:0] w_target_raw;
  logic [9:0]  w_fill_target;
  logic        w_filled, w_empty, w_in_fill, w_in_drain, w_in_run;
  logic        w_flow_err, w_drain_err, w_vib_err;
  logic        w_temp_rise, w_spin_rise;

  // Fill target 200 + 2*weight, saturated at 1000.
  assign w_target_raw  = 11'd200 + {2'b00, load_weight, 1'b0};
  assign w_fill_target = (w_target_raw > 11'd1000) ? 10'd1000 : w_target_raw[9:0];
  assign w_filled      = water_level_sensor >= w_fill_target;
  assign w_empty       = water_level_sensor <= EmptyLevel;

  assign w_in_fill  = (r_state == StFillInitial) || (r_state == StFillRinse);
  assign w_in_drain = (r_state == StDrainWash) || (r_state == StDrainRinse) ||
                      (r_state == StStopDrain);
  assign w_in_run   = (r_state >= StFillInitial) && (r_state <= StSpin);

  assign w_flow_err  = w_in_fill && !w_filled && ((r_fill_cnt + 8'd1) >= FillTimeout);
  assign w_drain_err = w_in_drain && !w_empty && ((r_drain_cnt + 8'd1) >= DrainTimeout);
  assign w_vib_err   = (r_state == StSpin) && vibration_sensor &&
                       ((r_vib_cnt + 8'd1) >= VibLimit);

  assign w_temp_rise = change_temperature && !r_chg_temp_q;
  assign w_spin_rise = change_spin_speed && !r_chg_spin_q;

  function automatic logic [6:0] step_temp(input logic [6:0] t);
    case (t)
      7'd20:   step_temp = 7'd30;
      7'd30:   step_temp = 7'd40;
      7'd40:   step_temp = 7'd60;
      7'd60:   step_temp = 7'd90;
      default: step_temp = 7'd20;
    endcase
  endfunction

  always_comb begin
    w_state_next     = r_state;
    w_prev_next      = r_prev_state;
    w_timer_next     = r_timer;
    w_fill_cnt_next  = r_fill_cnt;
    w_drain_cnt_next = r_drain_cnt;
    w_vib_cnt_next   = r_vib_cnt;
    w_sel_temp_next  = r_sel_temp;
    w_spin_code_next = r_spin_code;

    unique case (r_state)
      StIdle: begin
        if (start && clothes_loaded && door_locked && (load_weight != 8'd0) &&
            (load_weight <= MaxLoad)) begin
          w_state_next = StStart;
        end
      end
      StStart: begin
        if (w_temp_rise) w_sel_temp_next = step_temp(r_sel_temp);
        if (w_spin_rise) w_spin_code_next = r_spin_code + 2'd1;
        if (stop) begin
          w_state_next = StIdle;
        end else if (confirm_wash_mode) begin
          // Programme defaults override any manual step taken this cycle.
          case (wash_mode)
            3'd1:    begin w_sel_temp_next = 7'd30; w_spin_code_next = 2'd1; end
            3'd2:    begin w_sel_temp_next = 7'd20; w_spin_code_next = 2'd0; end
            3'd3:    begin w_sel_temp_next = 7'd30; w_spin_code_next = 2'd3; end
            3'd4:    begin w_sel_temp_next = 7'd60; w_spin_code_next = 2'd3; end
            default: begin w_sel_temp_next = 7'd40; w_spin_code_next = 2'd2; end
          endcase
          w_state_next = StFillInitial;
        end
      end
      StFillInitial, StFillRinse: begin
        if (w_filled) begin
          w_fill_cnt_next = '0;
          if (r_state == StFillInitial) w_state_next = StHeat;
          else begin
            w_state_next = StRinse;
            w_timer_next = '0;
          end
        end else begin
          w_fill_cnt_next = r_fill_cnt + 8'd1;
        end
      end
      StHeat: begin
        if (temperature_adc_sensor >= r_sel_temp) begin
          w_state_next = StWash;
          w_timer_next = '0;
        end
      end
      StWash: begin
        if (r_timer == WashLast) begin
          w_state_next = StDrainWash;
          w_timer_next = '0;
        end else begin
          w_timer_next = r_timer + 8'd1;
        end
      end
      StRinse: begin
        if (r_timer == RinseLast) begin
          w_state_next = StDrainRinse;
          w_timer_next = '0;
        end else begin
          w_timer_next = r_timer + 8'd1;
        end
      end
      StDrainWash, StDrainRinse, StStopDrain: begin
        if (w_empty) begin
          w_drain_cnt_next = '0;
          if (r_state == StDrainWash) w_state_next = StFillRinse;
          else if (r_state == StDrainRinse) begin
            w_state_next = StSpin;
            w_timer_next = '0;
          end else w_state_next = StIdle;
        end else begin
          w_drain_cnt_next = r_drain_cnt + 8'd1;
        end
      end
      StSpin: begin
        w_vib_cnt_next = vibration_sensor ? (r_vib_cnt + 8'd1) : 8'd0;
        if (r_timer == SpinLast) begin
          w_state_next   = StComplete;
          w_timer_next   = '0;
          w_vib_cnt_next = '0;
        end else begin
          w_timer_next = r_timer + 8'd1;
        end
      end
      StComplete: begin
        if (!start && !door_locked) w_state_next = StIdle;
      end
      StPaused: begin
        if (continue_signal) w_state_next = r_prev_state;
      end
      StError: begin
        // Only reset leaves ERROR.
      end
      default: w_state_next = StIdle;
    endcase

    // Priority: fault > stop > pause > the normal transition above.
    if (w_flow_err || w_drain_err || w_vib_err) begin
      w_state_next = StError;
    end else if (stop && (w_in_run || (r_state == StPaused))) begin
      w_state_next     = StStopDrain;
      w_timer_next     = '0;
      w_fill_cnt_next  = '0;
      w_drain_cnt_next = '0;
      w_vib_cnt_next   = '0;
    end else if (pause && w_in_run) begin
      // Freeze the phase timer and monitors so continue resumes where it left off.
      w_state_next     = StPaused;
      w_prev_next      = r_state;
      w_timer_next     = r_timer;
      w_fill_cnt_next  = r_fill_cnt;
      w_drain_cnt_next = r_drain_cnt;
      w_vib_cnt_next   = r_vib_cnt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state              <= StIdle;
      r_prev_state         <= StIdle;
      r_timer              <= '0;
      r_fill_cnt           <= '0;
      r_drain_cnt          <= '0;
      r_vib_cnt            <= '0;
      r_sel_temp           <= 7'd40;
      r_spin_code          <= 2'd0;
      r_chg_temp_q         <= 1'b0;
      r_chg_spin_q         <= 1'b0;
      cycle_complete_led   <= 1'b0;
      door_lock            <= 1'b0;
      water_valve          <= 1'b0;
      heater               <= 1'b0;
      drain_pump           <= 1'b0;
      drum_motor           <= 4'd0;
      water_flow_error_led <= 1'b0;
      drainage_error_led   <= 1'b0;
      vibration_error_led  <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_prev_state <= w_prev_next;
      r_timer      <= w_timer_next;
      r_fill_cnt   <= w_fill_cnt_next;
      r_drain_cnt  <= w_drain_cnt_next;
      r_vib_cnt    <= w_vib_cnt_next;
      r_sel_temp   <= w_sel_temp_next;
      r_spin_code  <= w_spin_code_next;
      r_chg_temp_q <= change_temperature;
      r_chg_spin_q <= change_spin_speed;

      // Outputs registered from the state being entered.
      cycle_complete_led <= (w_state_next == StComplete);
      water_valve <= ((w_state_next == StFillInitial) || (w_state_next == StFillRinse)) &&
                     !w_filled;
      heater      <= (w_state_next == StHeat) && (temperature_adc_sensor < w_sel_temp_next);
      drain_pump  <= (w_state_next == StDrainWash) || (w_state_next == StDrainRinse) ||
                     (w_state_next == StSpin) || (w_state_next == StStopDrain) ||
                     ((w_state_next == StError) && !w_empty);
      door_lock   <= ((w_state_next >= StFillInitial) && (w_state_next <= StSpin)) ||
                     (w_state_next == StPaused) || (w_state_next == StStopDrain) ||
                     ((w_state_next == StError) && !w_empty);
      if ((w_state_next == StWash) || (w_state_next == StRinse)) begin
        drum_motor <= 4'd3;
      end else if (w_state_next == StSpin) begin
        drum_motor <= 4'd8 + {1'b0, w_spin_code_next, 1'b0};
      end else begin
        drum_motor <= 4'd0;
      end

      water_flow_error_led <= water_flow_error_led | w_flow_err;
      drainage_error_led   <= drainage_error_led | w_drain_err;
      vibration_error_led  <= vibration_error_led | w_vib_err;
    end
  end

endmodule

// File: tb/tb_main_controller.sv
// Scoreboard bench for main_controller: each step pushes the expected output vector,
// waits one clock, then pops and compares it with the sampled DUT outputs.
// Output vector: {led, lock, valve, heater, pump, motor[3:0], flow_err, drain_err, vib_err}
module tb_main_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic       start, stop, pause, continue_signal;
  logic       door_locked, clothes_loaded;
  logic [7:0] load_weight;
  logic       vibration_sensor;
  logic [6:0] temperature_adc_sensor;
  logic [2:0] wash_mode;
  logic       confirm_wash_mode, change_temperature, change_spin_speed;
  logic [9:0] water_level_sensor;
  logic       cycle_complete_led, door_lock, water_valve, heater, drain_pump;
  logic [3:0] drum_motor;
  logic       water_flow_error_led, drainage_error_led, vibration_error_led;

  always #5 clk = ~clk;

  main_controller dut (
    .clk                   (clk),
    .reset                 (reset),
    .start                 (start),
    .stop                  (stop),
    .pause                 (pause),
    .continue_signal       (continue_signal),
    .door_locked           (door_locked),
    .clothes_loaded        (clothes_loaded),
    .load_weight           (load_weight),
    .vibration_sensor      (vibration_sensor),
    .temperature_adc_sensor(temperature_adc_sensor),
    .wash_mode             (wash_mode),
    .confirm_wash_mode     (confirm_wash_mode),
    .change_temperature    (change_temperature),
    .change_spin_speed     (change_spin_speed),
    .water_level_sensor    (water_level_sensor),
    .cycle_complete_led    (cycle_complete_led),
    .door_lock             (door_lock),
    .water_valve           (water_valve),
    .heater                (heater),
    .drain_pump            (drain_pump),
    .drum_motor            (drum_motor),
    .water_flow_error_led  (water_flow_error_led),
    .drainage_error_led    (drainage_error_led),
    .vibration_error_led   (vibration_error_led)
  );

  logic [11:0] obs;
  assign obs = {cycle_complete_led, door_lock, water_valve, heater, drain_pump, drum_motor,
                water_flow_error_led, drainage_error_led, vibration_error_led};

  localparam logic [11:0] OLed   = 12'h800;
  localparam logic [11:0] OLock  = 12'h400;
  localparam logic [11:0] OValve = 12'h200;
  localparam logic [11:0] OHeat  = 12'h100;
  localparam logic [11:0] OPump  = 12'h080;
  localparam logic [11:0] OFlow  = 12'h004;
  localparam logic [11:0] ODrain = 12'h002;
  localparam logic [11:0] OVib   = 12'h001;
  localparam logic [11:0] OMot3  = 12'h018;
  localparam logic [11:0] OMot12 = 12'h060;
  localparam logic [11:0] OMot14 = 12'h070;

  typedef struct {
    string       tag;
    logic [11:0] exp;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check_val(input string tag, input logic [11:0] got, input logic [11:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: outputs %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input string tag, input logic [11:0] e);
    exp_t it;
    it.tag = tag;
    it.exp = e;
    sb_q.push_back(it);
    @(posedge clk);
    #1;
    it = sb_q.pop_front();
    check_val(it.tag, obs, it.exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b0;
    #1;
    check_val(tag, obs, 12'h000);
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    {start, stop, pause, continue_signal} = '0;
    {door_locked, clothes_loaded, vibration_sensor} = '0;
    {confirm_wash_mode, change_temperature, change_spin_speed} = '0;
    load_weight = 8'd0;
    temperature_adc_sensor = 7'd20;
    wash_mode = 3'd0;
    water_level_sensor = 10'd0;
    repeat (3) @(posedge clk);
    #1;
    check_val("reset_outs", obs, 12'h000);
    reset = 1'b1;

    // Full cycle, mode 0, weight 50 (target 300), with a pause in WASH.
    start = 1'b1; clothes_loaded = 1'b1; door_locked = 1'b1;
    load_weight = 8'd201; confirm_wash_mode = 1'b1;
    step("reject_201", 12'h000);
    load_weight = 8'd0;
    step("reject_0", 12'h000);
    load_weight = 8'd150; door_locked = 1'b0;
    step("reject_door", 12'h000);
    door_locked = 1'b1; load_weight = 8'd50; confirm_wash_mode = 1'b0;
    step("to_start", 12'h000);
    confirm_wash_mode = 1'b1;
    step("confirm_fill", OLock | OValve);
    confirm_wash_mode = 1'b0; water_level_sensor = 10'd200; change_spin_speed = 1'b1;
    step("fill_200", OLock | OValve);
    change_spin_speed = 1'b0; water_level_sensor = 10'd300;
    step("fill_300_heat", OLock | OHeat);
    temperature_adc_sensor = 7'd30;
    step("heat_30", OLock | OHeat);
    temperature_adc_sensor = 7'd40;
    step("wash", OLock | OMot3);
    cyc(10);
    pause = 1'b1;
    step("pause", OLock);
    pause = 1'b0;
    cyc(19);
    step("paused_hold", OLock);
    continue_signal = 1'b1;
    step("resume", OLock | OMot3);
    continue_signal = 1'b0;
    cyc(18);
    step("wash_last", OLock | OMot3);
    step("drain_wash", OLock | OPump);
    water_level_sensor = 10'd5;
    step("fill_rinse", OLock | OValve);
    water_level_sensor = 10'd300;
    step("rinse", OLock | OMot3);
    cyc(18);
    step("rinse_last", OLock | OMot3);
    step("drain_rinse", OLock | OPump);
    water_level_sensor = 10'd0;
    step("spin", OLock | OPump | OMot12);
    vibration_sensor = 1'b1;
    for (int i = 0; i < 9; i++) step("spin_vib", OLock | OPump | OMot12);
    vibration_sensor = 1'b0;
    step("spin_vib_clr", OLock | OPump | OMot12);
    cyc(8);
    step("spin_last", OLock | OPump | OMot12);
    step("complete", OLed);
    step("complete_hold", OLed);
    start = 1'b0; door_locked = 1'b0;
    step("to_idle", 12'h000);

    // Wool, weight 200 (target 600), stop during RINSE.
    start = 1'b1; door_locked = 1'b1; load_weight = 8'd200;
    temperature_adc_sensor = 7'd20; wash_mode = 3'd2;
    step("b_start", 12'h000);
    confirm_wash_mode = 1'b1;
    step("b_fill", OLock | OValve);
    confirm_wash_mode = 1'b0; water_level_sensor = 10'd599;
    step("b_fill_599", OLock | OValve);
    water_level_sensor = 10'd600;
    step("b_heat_off", OLock);
    step("b_wash", OLock | OMot3);
    cyc(29);
    step("b_drain", OLock | OPump);
    water_level_sensor = 10'd0;
    step("b_fill_rinse", OLock | OValve);
    water_level_sensor = 10'd600;
    step("b_rinse", OLock | OMot3);
    cyc(3);
    stop = 1'b1;
    step("b_stop", OLock | OPump);
    stop = 1'b0;
    step("b_stop_hold", OLock | OPump);
    water_level_sensor = 10'd0;
    step("b_idle", 12'h000);

    // Water-flow timeout in FILL_INITIAL.
    load_weight = 8'd50; wash_mode = 3'd0;
    step("c_start", 12'h000);
    confirm_wash_mode = 1'b1;
    step("c_fill", OLock | OValve);
    confirm_wash_mode = 1'b0;
    cyc(48);
    step("c_fill_49", OLock | OValve);
    step("c_flow_err", OFlow);
    water_level_sensor = 10'd100;
    step("c_err_drain", OFlow | OLock | OPump);
    water_level_sensor = 10'd0;
    cyc(4);
    step("c_err_hold", OFlow);
    do_reset("reset_async_1");

    // Drainage timeout in STOP_DRAIN.
    water_level_sensor = 10'd300;
    step("d_start", 12'h000);
    confirm_wash_mode = 1'b1;
    step("d_fill_full", OLock);
    confirm_wash_mode = 1'b0; stop = 1'b1;
    step("d_stop", OLock | OPump);
    stop = 1'b0;
    cyc(48);
    step("d_drain_49", OLock | OPump);
    step("d_drain_err", ODrain | OLock | OPump);
    do_reset("reset_async_2");

    // Quick mode (spin code 3) and a vibration fault in SPIN.
    wash_mode = 3'd3; temperature_adc_sensor = 7'd90; water_level_sensor = 10'd300;
    step("e_start", 12'h000);
    confirm_wash_mode = 1'b1;
    step("e_fill_full", OLock);
    confirm_wash_mode = 1'b0;
    cyc(32);
    water_level_sensor = 10'd0;
    cyc(1);
    water_level_sensor = 10'd300;
    cyc(21);
    water_level_sensor = 10'd0;
    step("e_spin", OLock | OPump | OMot14);
    vibration_sensor = 1'b1;
    cyc(8);
    step("e_vib_9", OLock | OPump | OMot14);
    step("e_vib_err", OVib);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/main_controller.md
Name: main_controller

Overview:
- Top-level sequencer for a domestic washing machine.
- Accepts user buttons, door/load/water/temperature/vibration sensors and wash-mode settings, and drives the valve, heater, drain pump, drum motor, door lock and status LEDs.
- Contains the cycle FSM, the selected-temperature/spin registers, phase timers and three fault monitors (water flow, drainage, vibration).
- One clock cycle is 200 ms.

Parameters:
- MAX_LOAD, 200: maximum accepted load_weight.
- WASH_CYCLES, 30: WASH duration in cycles.
- RINSE_CYCLES, 20: RINSE duration in cycles.
- SPIN_CYCLES, 20: SPIN duration in cycles.
- FILL_TIMEOUT, 50: fill cycles allowed before water-flow error.
- DRAIN_TIMEOUT, 50: drain cycles allowed before drainage error.
- VIB_LIMIT, 10: consecutive vibration cycles in SPIN before vibration error.
- EMPTY_LEVEL, 10: water level at or below which the drum counts as empty.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- start, stop, pause, continue_signal  in  1 each  user buttons, level-sampled
- door_locked  in  1  1 = door latched
- clothes_loaded  in  1  load present
- load_weight  in  8  load weight
- vibration_sensor  in  1  1 = excessive vibration
- temperature_adc_sensor  in  7  water temperature in °C
- wash_mode  in  3  programme select
- confirm_wash_mode  in  1  latch programme
- change_temperature, change_spin_speed  in  1 each  step selection on rising edge
- water_level_sensor  in  10  water level
- cycle_complete_led  out  1  cycle complete indicator
- door_lock  out  1  door lock actuator
- water_valve  out  1  water valve actuator
- heater  out  1  heater actuator
- drain_pump  out  1  drain pump actuator
- drum_motor  out  4  drum speed level, 0 = off
- water_flow_error_led, drainage_error_led, vibration_error_led  out  1 each  fault indicators

Behaviour:
- Reset: asynchronous, active-low. While asserted: state=IDLE, prev_state=IDLE, all outputs 0, timers/counters 0, temperature=40, spin code=0.
- All outputs are registered or decoded from state only.
- States (4-bit): IDLE=0, START=1, FILL_INITIAL=2, HEAT=3, WASH=4, DRAIN_WASH=5, FILL_RINSE=6, RINSE=7, DRAIN_RINSE=8, SPIN=9, COMPLETE=10, PAUSED=11, STOP_DRAIN=12, ERROR=13.
- Priority per cycle: error detection > stop > pause > normal transition.
- IDLE -> START: start & clothes_loaded & door_locked & 0<load_weight<=MAX_LOAD. Otherwise stay in IDLE.
- START:
  - Rising edge on change_temperature steps temperature 20->30->40->60->90->20.
  - Rising edge on change_spin_speed steps spin code 0..3, wrapping.
  - confirm_wash_mode -> FILL_INITIAL; latches mode defaults on that edge: 0 cotton 40°C/code 2; 1 synthetic 30/1; 2 wool 20/0; 3 quick 30/3; 4 heavy 60/3; 5-7 as mode 0.
  - Manual steps made after confirm are not applied.
  - stop -> IDLE.
- Fill target = 200 + 2*load_weight, saturating at 1000 (e.g. weight 50 -> 300).
- FILL_INITIAL / FILL_RINSE:
  - water_valve=1 while level < target.
  - Level >= target -> HEAT (from FILL_INITIAL) or RINSE (from FILL_RINSE).
- HEAT:
  - heater=1 while temperature < selected temperature.
  - Temperature >= selected -> WASH in the next cycle.
- WASH / RINSE: drum_motor=3; exit to DRAIN_WASH / DRAIN_RINSE after WASH_CYCLES / RINSE_CYCLES.
- Drain states: drain_pump=1; level <= EMPTY_LEVEL -> FILL_RINSE (from DRAIN_WASH) or SPIN (from DRAIN_RINSE).
- SPIN: drain_pump=1, drum_motor = 8 + 2*spin code (8/10/12/14); SPIN_CYCLES -> COMPLETE.
- COMPLETE: cycle_complete_led=1, door_lock=0; -> IDLE when start is low and door_locked is low.
- door_lock=1 in every state from FILL_INITIAL to SPIN, plus PAUSED, STOP_DRAIN and ERROR.
- Pause: allowed in states 2-9. Records prev_state, enters PAUSED.
  - In PAUSED: actuators off, door_lock held, phase timers and monitor counters frozen.
  - continue_signal -> prev_state, with the timer resuming from its frozen value.
- Stop: from states 2-9 or PAUSED -> STOP_DRAIN.
  - STOP_DRAIN: drain_pump=1 until level <= EMPTY_LEVEL, then IDLE.
- Water-flow monitor:
  - Counter increments each cycle in a fill state while level < target.
  - Counter clears on leaving the fill state.
  - Reaching FILL_TIMEOUT sets water_flow_error_led and enters ERROR.
- Drainage monitor: same scheme in drain states and STOP_DRAIN, using DRAIN_TIMEOUT; sets drainage_error_led.
- Vibration monitor: counts consecutive vibration_sensor=1 cycles in SPIN and clears on any 0; reaching VIB_LIMIT sets vibration_error_led.
- ERROR:
  - Water valve, heater and motor off.
  - drain_pump=1 until empty.
  - door_lock=1 until empty.
  - Error LEDs latched; only reset exits ERROR.
- Timer counts are width-safe (>= 8 bits); all comparisons are unsigned.

Test Plan:
- Reset released; start=1, clothes_loaded=1, door_locked=1, weight 50 -> START within 1 cycle; confirm, mode 0 -> FILL_INITIAL, water_valve=1.
- Level 200 then 300 -> valve stays on at 200; at 300 the FSM goes to HEAT with heater=1. Temperature 40 -> WASH, drum_motor=3.
- Full cycle with drains reaching 0 -> passes through RINSE; SPIN with drum_motor=12 for mode 0; COMPLETE with cycle_complete_led=1.
- Level held at 0 in FILL_INITIAL for 50 cycles -> water_flow_error_led=1, ERROR, valve off; holds until reset.
- Pause in WASH at timer 10, hold 20 cycles, continue -> WASH resumes, 20 cycles remaining; stop in RINSE -> STOP_DRAIN, then IDLE.
- vibration_sensor=1 for 10 cycles in SPIN -> vibration_error_led=1; 9 cycles then a 0 -> no error.
